mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single main-memory port between the instruction-cache controller (requester 0) and the data-cache controller (requester 1).
- Latches one request and drives main_read or main_write until the memory returns ready, then returns the 128-bit block and a one-cycle done pulse.
- Grants alternate round-robin when both requesters are pending.
- A watchdog aborts a transaction if memory never answers.

Parameters:
- ADDR_W, 10, word/byte address width forwarded to main memory.
- BLOCK_W, 128, refill block width (4 x 32-bit words).
- TIMEOUT, 64, maximum wait cycles for mem_ready; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_neg  in  1  asynchronous, active-high reset (1 = reset asserted).
- rd_req  in  2  per-requester read request, bit n = requester n; held until done[n].
- wr_req  in  2  per-requester write-through request; held until done[n].
- addr0  in  ADDR_W  requester 0 address.
- addr1  in  ADDR_W  requester 1 address.
- wdata0  in  32  requester 0 write data.
- wdata1  in  32  requester 1 write data.
- done  out  2  one-cycle completion pulse for the served requester.
- err  out  2  one-cycle timeout flag, coincident with done.
- rdata  out  BLOCK_W  returned block; valid while done is high, held until the next done.
- busy  out  1  high whenever state != IDLE.
- main_read  out  1  memory read strobe.
- main_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  32  latched write data.
- mem_ready  in  1  memory completion, sampled on clk.
- mem_block  in  BLOCK_W  memory read data, valid with mem_ready.

Behaviour:
- Reset, async, any state: state=IDLE, last_grant=1 (so requester 0 wins the first tie). done, err, main_read, main_write, busy = 0; rdata, mem_addr, mem_wdata = 0; watchdog counter = 0.
- States: IDLE, ACCESS, DONE.
- Pending for requester n means rd_req[n] | wr_req[n]. If both bits are set for one requester, the access is a write.
- IDLE:
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the one != last_grant.
  - On grant: latch requester id, op, address and wdata into mem_addr/mem_wdata; set last_grant; go to ACCESS.
  - Nothing pending: stay in IDLE.
- ACCESS:
  - main_read or main_write is high, starting the cycle after the grant edge.
  - mem_addr and mem_wdata stay stable throughout.
  - The counter increments each cycle that mem_ready is low.
  - mem_ready=1 on an edge: capture mem_block into rdata (reads only; writes leave rdata unchanged), drop strobes, go to DONE.
  - TIMEOUT != 0 and counter reaches TIMEOUT-1 with mem_ready low: drop strobes, set rdata=0, flag err, go to DONE.
- DONE (exactly one cycle):
  - done[id]=1, plus err[id]=1 on timeout.
  - Counter cleared; next state IDLE.
  - The requester must deassert its request on the edge that ends DONE, so IDLE never re-grants a completed request.
- Latency:
  - Request seen in IDLE at cycle 0 -> strobe high at cycles 1..k, where k is the cycle mem_ready is sampled -> done at cycle k+1.
  - Minimum 3 cycles, request to done.
- Requests arriving while busy are not lost; they are held by the requester and arbitrated at the next IDLE. Strict alternation under contention bounds the wait to one transaction.
- Request inputs are ignored outside IDLE, including a requester dropping its request mid-access. The access completes and done still pulses.
- main_read and main_write are never high together; both are low in IDLE and DONE.
- mem_ready while in IDLE or DONE is ignored.
- Reset asserted mid-access: strobes drop asynchronously and the transaction is discarded with no done pulse.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2);
  - op encoding (OP_RD=0, OP_WR=1);
  - requester ids (REQ_ICACHE=0, REQ_DCACHE=1).
- One natural sub-module: rr_pick2, a combinational two-way round-robin selector taking pending[1:0] and last_grant, producing grant_valid and grant_id.
- The FSM, latches and watchdog stay in the top.

Test Plan:
- Single read: rd_req=2'b01, addr0=10'h084, memory answers mem_ready at the 3rd ACCESS cycle with mem_block=128'hA5... -> main_read high 3 cycles, mem_addr=10'h084, done=2'b01 one cycle later, rdata=128'hA5..., main_write never high.
- Write-through: wr_req=2'b10, addr1=10'h3FC, wdata1=32'hDEADBEEF -> main_write high, mem_wdata=32'hDEADBEEF until mem_ready, done=2'b10, rdata unchanged.
- Contention:
  - both rd_req bits held continuously from reset -> grant order 0,1,0,1 over four transactions;
  - after requester 1 completes alone, a tie grants 0.
- Timeout with TIMEOUT=8 and mem_ready tied 0: rd_req=2'b10 -> strobe high exactly 8 cycles, then done=2'b10 and err=2'b10 for one cycle, rdata=0, busy low next cycle.
- Reset mid-access: assert reset_neg on the 2nd ACCESS cycle -> main_read, busy and done go 0 immediately with no done pulse. After release with rd_req=2'b11 held, requester 0 is granted first.
- Both-op request: rd_req=2'b01 and wr_req=2'b01 together -> only main_write asserted; mem_ready asserted while in IDLE beforehand has no effect.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester main-memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Memory operation of the latched request.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Requester identities.
  localparam logic REQ_ICACHE = 1'b0;
  localparam logic REQ_DCACHE = 1'b1;

  // One-hot completion vector for a requester id.
  function automatic logic [1:0] req_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Main-memory port bundle: strobes, latched address/data, ready and refill block.
interface mem_port_arbiter_if #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128
) ();

  logic               main_read;
  logic               main_write;
  logic [ADDR_W-1:0]  mem_addr;
  logic [31:0]        mem_wdata;
  logic               mem_ready;
  logic [BLOCK_W-1:0] mem_block;

  // Arbiter side drives the strobes and latched request.
  modport master (
    output main_read,
    output main_write,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_block
  );

  // Memory side answers with ready and the refill block.
  modport slave (
    input  main_read,
    input  main_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_block
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin selector. A lone pending
// requester always wins; on a tie the one that was not granted last wins.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] pending,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  // Pick the winner from the pending vector and the previous grant.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_ICACHE;
    case (pending)
      2'b01: begin
        grant_valid = 1'b1;
        grant_id    = REQ_ICACHE;
      end
      2'b10: begin
        grant_valid = 1'b1;
        grant_id    = REQ_DCACHE;
      end
      2'b11: begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end
      default: begin
        grant_valid = 1'b0;
        grant_id    = REQ_ICACHE;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache (requester 0) and the
// D-cache (requester 1). Latches one request, strobes memory until ready or
// watchdog expiry, then pulses done (and err on timeout) for one cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset_neg,
  input  logic [1:0]          rd_req,
  input  logic [1:0]          wr_req,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [31:0]         wdata0,
  input  logic [31:0]         wdata1,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic [BLOCK_W-1:0]  rdata,
  output logic                busy,
  mem_port_arbiter_if.master  mem
);

  // Watchdog counter only has to reach TIMEOUT-1.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_r;
  op_t               op_r;
  logic              id_r;
  logic              last_grant_r;
  logic [CNT_W-1:0]  cnt_r;

  logic [1:0]        pending_s;
  logic              grant_valid_s;
  logic              grant_id_s;
  op_t               sel_op_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s;

  assign pending_s = rd_req | wr_req;

  mem_port_arbiter_rr_pick2 u_pick (
    .pending     (pending_s),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Route the winning requester's op/address/data; write wins when both ops are set.
  always_comb begin
    sel_op_s    = OP_RD;
    sel_addr_s  = addr0;
    sel_wdata_s = wdata0;
    if (grant_id_s == REQ_DCACHE) begin
      sel_op_s    = wr_req[1] ? OP_WR : OP_RD;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_op_s    = wr_req[0] ? OP_WR : OP_RD;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  // Arbitration FSM with latched request, watchdog and registered outputs.
  always_ff @(posedge clk or posedge reset_neg) begin
    if (reset_neg) begin
      state_r        <= ST_IDLE;
      op_r           <= OP_RD;
      id_r           <= REQ_ICACHE;
      last_grant_r   <= REQ_DCACHE;
      cnt_r          <= CNT_W'(0);
      done           <= 2'b00;
      err            <= 2'b00;
      busy           <= 1'b0;
      rdata          <= {BLOCK_W{1'b0}};
      mem.main_read  <= 1'b0;
      mem.main_write <= 1'b0;
      mem.mem_addr   <= {ADDR_W{1'b0}};
      mem.mem_wdata  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 2'b00;
          err  <= 2'b00;
          if (grant_valid_s) begin
            id_r           <= grant_id_s;
            op_r           <= sel_op_s;
            last_grant_r   <= grant_id_s;
            mem.mem_addr   <= sel_addr_s;
            mem.mem_wdata  <= sel_wdata_s;
            mem.main_read  <= (sel_op_s == OP_RD);
            mem.main_write <= (sel_op_s == OP_WR);
            busy           <= 1'b1;
            state_r        <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (mem.mem_ready) begin
            mem.main_read  <= 1'b0;
            mem.main_write <= 1'b0;
            if (op_r == OP_RD) begin
              rdata <= mem.mem_block;
            end
            done    <= req_onehot(id_r);
            state_r <= ST_DONE;
          end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
            // Memory never answered: give up and report the error.
            mem.main_read  <= 1'b0;
            mem.main_write <= 1'b0;
            rdata          <= {BLOCK_W{1'b0}};
            done           <= req_onehot(id_r);
            err            <= req_onehot(id_r);
            state_r        <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          done    <= 2'b00;
          err     <= 2'b00;
          cnt_r   <= CNT_W'(0);
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          // Unreachable encoding: recover to a quiet idle port.
          mem.main_read  <= 1'b0;
          mem.main_write <= 1'b0;
          done           <= 2'b00;
          err            <= 2'b00;
          cnt_r          <= CNT_W'(0);
          busy           <= 1'b0;
          state_r        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 10;
  localparam int BLOCK_W = 128;
  localparam int TO      = 8;

  logic               clk = 1'b0;
  logic               reset_neg;
  logic [1:0]         rd_req, wr_req;
  logic [ADDR_W-1:0]  addr0, addr1;
  logic [31:0]        wdata0, wdata1;
  logic [1:0]         done, err;
  logic [BLOCK_W-1:0] rdata;
  logic               busy;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) mem_bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset_neg (reset_neg),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .mem       (mem_bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // ---------------- transaction-level reference model ----------------
  logic               exp_read, exp_write, exp_busy;
  logic [ADDR_W-1:0]  exp_addr;
  logic [31:0]        exp_wdata;
  logic [1:0]         exp_done, exp_err;
  logic [BLOCK_W-1:0] exp_rdata;
  bit                 m_active, m_finishing, m_write, m_id, m_last;
  int                 m_waited;

  task automatic model_reset();
    exp_read = 1'b0; exp_write = 1'b0; exp_busy = 1'b0;
    exp_addr = '0; exp_wdata = 32'd0; exp_done = 2'b00; exp_err = 2'b00;
    exp_rdata = '0;
    m_active = 1'b0; m_finishing = 1'b0; m_write = 1'b0; m_id = 1'b0;
    m_last = 1'b1; m_waited = 0;
  endtask

  task automatic model_step();
    logic [1:0] pend;
    if (m_finishing) begin
      m_finishing = 1'b0;
      exp_done = 2'b00; exp_err = 2'b00; exp_busy = 1'b0;
    end else if (m_active) begin
      m_waited++;
      if (mem_bus.mem_ready) begin
        m_active = 1'b0; m_finishing = 1'b1;
        exp_read = 1'b0; exp_write = 1'b0;
        if (!m_write) exp_rdata = mem_bus.mem_block;
        exp_done = 2'b01 << m_id;
      end else if (m_waited >= TO) begin
        m_active = 1'b0; m_finishing = 1'b1;
        exp_read = 1'b0; exp_write = 1'b0;
        exp_rdata = '0;
        exp_done = 2'b01 << m_id;
        exp_err  = 2'b01 << m_id;
      end
    end else begin
      pend = rd_req | wr_req;
      if (pend != 2'b00) begin
        m_id      = (pend == 2'b11) ? !m_last : pend[1];
        m_write   = wr_req[m_id];
        exp_addr  = m_id ? addr1 : addr0;
        exp_wdata = m_id ? wdata1 : wdata0;
        exp_read  = !m_write;
        exp_write = m_write;
        exp_busy  = 1'b1;
        m_last    = m_id;
        m_active  = 1'b1;
        m_waited  = 0;
      end
    end
  endtask

  // Model advances on the same edges as the design.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset_neg);
      if (reset_neg) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("main_read",  mem_bus.main_read,  exp_read);
    check("main_write", mem_bus.main_write, exp_write);
    check("mem_addr",   mem_bus.mem_addr,   exp_addr);
    check("mem_wdata",  mem_bus.mem_wdata,  exp_wdata);
    check("done",       done,               exp_done);
    check("err",        err,                exp_err);
    check("rdata",      rdata,              exp_rdata);
    check("busy",       busy,               exp_busy);
  end

  // ---------------- directed helpers ----------------
  // Runs one transaction whose request is already driven; memory answers
  // after ready_at strobe cycles (0 = never). Returns at the done cycle.
  task automatic serve(input int ready_at, input bit drop,
                       output int n_rd, output int n_wr,
                       output logic [1:0] d, output logic [1:0] e);
    n_rd = 0; n_wr = 0; d = 2'b00; e = 2'b00;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_bus.main_read)  n_rd++;
      if (mem_bus.main_write) n_wr++;
      if (done != 2'b00) begin
        d = done; e = err;
        mem_bus.mem_ready = 1'b0;
        if (drop) begin
          rd_req = rd_req & ~done;
          wr_req = wr_req & ~done;
        end
        break;
      end
      mem_bus.mem_ready = (ready_at != 0) && (mem_bus.main_read || mem_bus.main_write)
                          && ((n_rd + n_wr) == ready_at);
    end
    check("serve_completed", (d != 2'b00), 1'b1);
  endtask

  int         n_rd, n_wr, hits, rop;
  logic [1:0] d, e, hold;
  logic [1:0] order [4];

  initial begin
    reset_neg = 1'b1;
    rd_req = 2'b00; wr_req = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = 32'd0; wdata1 = 32'd0;
    mem_bus.mem_ready = 1'b0; mem_bus.mem_block = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",  busy, 1'b0);
    check("reset_done",  done, 2'b00);
    check("reset_rdata", rdata, 128'd0);
    check("reset_read",  mem_bus.main_read, 1'b0);
    reset_neg = 1'b0;

    // Single read from requester 0, ready on the 3rd access cycle.
    rd_req = 2'b01; addr0 = 10'h084;
    mem_bus.mem_block = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    serve(3, 1'b1, n_rd, n_wr, d, e);
    check("rd_strobe_cycles", n_rd, 3);
    check("rd_no_write", n_wr, 0);
    check("rd_done", d, 2'b01);
    check("rd_err", e, 2'b00);
    check("rd_rdata", rdata, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5);
    check("rd_addr", mem_bus.mem_addr, 10'h084);

    // Write-through from requester 1; rdata must not change.
    wr_req = 2'b10; addr1 = 10'h3FC; wdata1 = 32'hDEADBEEF;
    mem_bus.mem_block = 128'h11111111_22222222_33333333_44444444;
    serve(2, 1'b1, n_rd, n_wr, d, e);
    check("wr_strobe_cycles", n_wr, 2);
    check("wr_no_read", n_rd, 0);
    check("wr_done", d, 2'b10);
    check("wr_wdata", mem_bus.mem_wdata, 32'hDEADBEEF);
    check("wr_addr", mem_bus.mem_addr, 10'h3FC);
    check("wr_rdata_held", rdata, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5);

    // Contention from reset: both reads held -> 0,1,0,1.
    #2 reset_neg = 1'b1;
    rd_req = 2'b11;
    @(negedge clk);
    reset_neg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(1, 1'b0, n_rd, n_wr, d, e);
      order[i] = d;
    end
    check("rr_0", order[0], 2'b01);
    check("rr_1", order[1], 2'b10);
    check("rr_2", order[2], 2'b01);
    check("rr_3", order[3], 2'b10);
    rd_req = 2'b10;
    serve(1, 1'b1, n_rd, n_wr, d, e);
    check("solo_1", d, 2'b10);
    rd_req = 2'b11;
    serve(1, 1'b1, n_rd, n_wr, d, e);
    check("tie_after_1", d, 2'b01);
    rd_req = 2'b00;

    // Watchdog: memory never answers.
    rd_req = 2'b10;
    serve(0, 1'b1, n_rd, n_wr, d, e);
    check("to_strobe_cycles", n_rd, TO);
    check("to_done", d, 2'b10);
    check("to_err", e, 2'b10);
    check("to_rdata", rdata, 128'd0);
    @(negedge clk);
    check("to_busy_after", busy, 1'b0);

    // Reset on the 2nd access cycle discards the transaction.
    rd_req = 2'b01; hits = 0;
    for (int k = 0; k < 10 && hits < 2; k++) begin
      @(negedge clk);
      if (mem_bus.main_read) hits++;
    end
    check("rst_mid_reached", hits, 2);
    #2 reset_neg = 1'b1;
    #1;
    check("rst_mid_read", mem_bus.main_read, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", done, 2'b00);
    rd_req = 2'b11;
    @(negedge clk);
    reset_neg = 1'b0;
    serve(1, 1'b1, n_rd, n_wr, d, e);
    check("rst_first_grant", d, 2'b01);
    rd_req = 2'b00;

    // Both ops from requester 0 -> write; stray ready in idle is ignored.
    @(negedge clk);
    mem_bus.mem_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_busy", busy, 1'b0);
      check("idle_ready_done", done, 2'b00);
    end
    mem_bus.mem_ready = 1'b0;
    rd_req = 2'b01; wr_req = 2'b01; wdata0 = 32'h0BADF00D;
    serve(2, 1'b1, n_rd, n_wr, d, e);
    check("both_write_cycles", n_wr, 2);
    check("both_no_read", n_rd, 0);
    check("both_done", d, 2'b01);
    rd_req = 2'b00; wr_req = 2'b00;

    // Randomized traffic checked by the model.
    hold = 2'b00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1502) reset_neg = 1'b0;
      if (cyc == 1500) #2 reset_neg = 1'b1;
      mem_bus.mem_ready = ($urandom_range(0, 2) == 0);
      mem_bus.mem_block = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int n = 0; n < 2; n++) begin
        if (hold[n]) begin
          if (done[n]) begin
            hold[n] = 1'b0; rd_req[n] = 1'b0; wr_req[n] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          rop = $urandom_range(0, 2);
          rd_req[n] = (rop != 1);
          wr_req[n] = (rop != 0);
          hold[n] = 1'b1;
          if (n == 0) begin
            addr0 = ADDR_W'($urandom()); wdata0 = $urandom();
          end else begin
            addr1 = ADDR_W'($urandom()); wdata1 = $urandom();
          end
        end
      end
    end
    rd_req = 2'b00; wr_req = 2'b00; mem_bus.mem_ready = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
